// File: rtl/boot_hex_pkg.sv
// -----------------------------------------------------------------------------
// boot_hex_pkg
// Definitions shared by the boot hex formatter (transmit side) and the boot
// hex loader parser (receive side): ASCII character constants, the line state
// enum and the nibble width.
// -----------------------------------------------------------------------------
package boot_hex_pkg;

  localparam int nibble_width = 4;

  localparam logic [7:0] CH_0     = 8'h30;  // "0"
  localparam logic [7:0] CH_A     = 8'h41;  // "A"
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COLON = 8'h3A;  // ":"
  localparam logic [7:0] CH_SPACE = 8'h20;  // " "

  // ST_ADDR and ST_SEP are only visited when the address prefix is enabled.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SEP,
    ST_DATA,
    ST_CR,
    ST_LF
  } state_t;

endpackage

// File: rtl/boot_hex_formatter_nibble.sv
// -----------------------------------------------------------------------------
// hex_nibble_to_char
// Combinational mapper from one 4-bit nibble to its uppercase ASCII hex digit.
// Ports:
//   i_nibble  in   nibble_width  value 0..15
//   o_char    out  8             "0".."9", "A".."F"
// -----------------------------------------------------------------------------
module hex_nibble_to_char
  import boot_hex_pkg::*;
(
  input  logic [nibble_width-1:0] i_nibble,
  output logic [7:0]              o_char
);

  always_comb begin
    if (i_nibble < 4'd10) begin
      o_char = CH_0 + {4'd0, i_nibble};
    end else begin
      o_char = CH_A + {4'd0, i_nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/boot_hex_formatter.sv
// -----------------------------------------------------------------------------
// boot_hex_formatter
// Turns one binary word per line into ASCII hex text (MSB nibble first)
// terminated by CR LF, for a byte-wide transmitter such as a UART.
//
// Optional feature (macro BOOT_HEX_FORMATTER_ADDRESS_EN):
//   when defined, every line is prefixed by the latched line address in hex
//   followed by ": ", e.g. "00000004: DEADBEEF\r\n". When undefined, lines
//   carry the data digits only, e.g. "DEADBEEF\r\n".
//
// Ports:
//   clk        in   1              clock
//   reset      in   1              asynchronous active-high reset
//   in_valid   in   1              word available
//   in_data    in   data_width     word to format
//   in_ready   out  1              high in IDLE only
//   restart    in   1              pulse: zero the line address counter
//   out_valid  out  1              character available (registered)
//   out_char   out  char_width     ASCII character (registered)
//   out_ready  in   1              character consumed
//   busy       out  1              a line is in progress
// -----------------------------------------------------------------------------
module boot_hex_formatter
  import boot_hex_pkg::*;
#(
  parameter int address_width = 32,
  parameter int data_width    = 32,
  parameter int char_width    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  output logic                  in_ready,
  input  logic                  restart,
  output logic                  out_valid,
  output logic [char_width-1:0] out_char,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam logic [7:0] DATA_LAST = 8'(data_width / nibble_width);
`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
  localparam logic [7:0] ADDR_LAST = 8'(address_width / nibble_width);
`endif
  localparam logic [address_width-1:0] ADDR_INC = address_width'(data_width / 8);

  state_t                  r_state;
  logic [data_width-1:0]   r_data_sh;
  logic [address_width-1:0] r_addr_cnt;
`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
  logic [address_width-1:0] r_addr_sh;
`endif
  logic [7:0]              r_cnt;
  logic                    r_out_valid;
  logic [char_width-1:0]   r_out_char;

  logic                     w_in_hs;
  logic                     w_out_hs;
  logic [address_width-1:0] w_line_addr;
  logic [nibble_width-1:0]  w_nibble;
  logic [7:0]               w_hex_char;

  function automatic logic [char_width-1:0] to_char(input logic [7:0] c);
    return char_width'(c);
  endfunction

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = r_out_valid;
  assign out_char  = r_out_char;

  assign w_in_hs  = in_valid & in_ready;
  assign w_out_hs = r_out_valid & out_ready;

  // A restart coinciding with the handshake gives the accepted word address 0.
  assign w_line_addr = restart ? '0 : r_addr_cnt;

  // The next digit to present: in IDLE it comes straight from the incoming
  // line (so the first character is valid the cycle after acceptance),
  // otherwise from the top of the active shift register.
  always_comb begin
    w_nibble = r_data_sh[data_width-1 -: nibble_width];
    case (r_state)
`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
      ST_IDLE: w_nibble = w_line_addr[address_width-1 -: nibble_width];
      ST_ADDR: w_nibble = r_addr_sh[address_width-1 -: nibble_width];
`else
      ST_IDLE: w_nibble = in_data[data_width-1 -: nibble_width];
`endif
      default: ;
    endcase
  end

  hex_nibble_to_char u_nibble (
    .i_nibble (w_nibble),
    .o_char   (w_hex_char)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_data_sh   <= '0;
      r_addr_cnt  <= '0;
`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
      r_addr_sh   <= '0;
`endif
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_char  <= '0;
    end else begin
      if (w_in_hs) begin
        r_addr_cnt <= w_line_addr + ADDR_INC;
      end else if (restart) begin
        r_addr_cnt <= '0;
      end

      // r_cnt counts digits already loaded into r_out_char for the field.
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_out_valid <= 1'b1;
            r_out_char  <= to_char(w_hex_char);
            r_cnt       <= 8'd1;
`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
            r_addr_sh   <= w_line_addr << nibble_width;
            r_data_sh   <= in_data;
            r_state     <= ST_ADDR;
`else
            r_data_sh   <= in_data << nibble_width;
            r_state     <= ST_DATA;
`endif
          end
        end
`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
        ST_ADDR: begin
          if (w_out_hs) begin
            if (r_cnt == ADDR_LAST) begin
              r_out_char <= to_char(CH_COLON);
              r_cnt      <= 8'd0;
              r_state    <= ST_SEP;
            end else begin
              r_out_char <= to_char(w_hex_char);
              r_addr_sh  <= r_addr_sh << nibble_width;
              r_cnt      <= r_cnt + 8'd1;
            end
          end
        end
        // r_cnt 0: ":" on the wire, 1: " " on the wire.
        ST_SEP: begin
          if (w_out_hs) begin
            if (r_cnt == 8'd0) begin
              r_out_char <= to_char(CH_SPACE);
              r_cnt      <= 8'd1;
            end else begin
              r_out_char <= to_char(w_hex_char);
              r_data_sh  <= r_data_sh << nibble_width;
              r_cnt      <= 8'd1;
              r_state    <= ST_DATA;
            end
          end
        end
`endif
        ST_DATA: begin
          if (w_out_hs) begin
            if (r_cnt == DATA_LAST) begin
              r_out_char <= to_char(CH_CR);
              r_state    <= ST_CR;
            end else begin
              r_out_char <= to_char(w_hex_char);
              r_data_sh  <= r_data_sh << nibble_width;
              r_cnt      <= r_cnt + 8'd1;
            end
          end
        end
        ST_CR: begin
          if (w_out_hs) begin
            r_out_char <= to_char(CH_LF);
            r_state    <= ST_LF;
          end
        end
        ST_LF: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_hex_formatter.sv
module tb_boot_hex_formatter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        restart;
  logic        out_valid;
  logic [7:0]  out_char;
  logic        out_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] sent_q[$];
  logic [31:0] m_addr;
  int          g_base;
  int          rdy_mode;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_char  = 8'h00;

  always #5 clk = ~clk;

  boot_hex_formatter #(
    .address_width (32),
    .data_width    (32),
    .char_width    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .restart   (restart),
    .out_valid (out_valid),
    .out_char  (out_char),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Character collector and stall-stability observer.
  always @(posedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_char !== prev_char))
        stall_viol <= stall_viol + 1;
      if (out_valid && out_ready) got_q.push_back(out_char);
      prev_stall <= out_valid && !out_ready;
      prev_char  <= out_char;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  // Reference: the text line the spec prescribes for word w.
  task automatic model_word(input logic [31:0] w, input logic rs);
    logic [31:0] a;
    a = rs ? 32'd0 : m_addr;
`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
    for (int i = 7; i >= 0; i--) exp_q.push_back(hexc(int'((a >> (4 * i)) & 32'hF)));
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'h20);
`endif
    for (int i = 7; i >= 0; i--) exp_q.push_back(hexc(int'((w >> (4 * i)) & 32'hF)));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    m_addr = a + 32'd4;
    sent_q.push_back(w);
  endtask

  task automatic send_word(input logic [31:0] w, input logic rs);
    logic hs;
    int   n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    restart  = rs;
    forever begin
      hs = in_ready;
      step();
      if (hs) break;
      n++;
      if (n > 500) begin
        check("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
    restart  = 1'b0;
  endtask

  task automatic wait_and_compare(input string tag);
    int n;
    n = 0;
    while (got_q.size() < g_base + exp_q.size() && n < 5000) begin
      step();
      n++;
    end
    repeat (3) step();
    check({tag, "_count"}, 64'(got_q.size() - g_base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (g_base + i < got_q.size())
        check($sformatf("%s[%0d]", tag, i), got_q[g_base + i], exp_q[i]);
    end
    g_base = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0]  line1[10];
    logic [31:0] w;
    logic [31:0] val;
    logic [7:0]  c;
    int          rbase;
    int          lines;
    int          perr;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    restart   = 1'b0;
    out_ready = 1'b1;
    rdy_mode  = 0;
    m_addr    = 32'd0;
    g_base    = 0;

    fork
      forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
          1:       out_ready = ~out_ready;
          2:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = 1'b1;
        endcase
      end
    join_none

    // Reset state
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_char", out_char, 8'h00);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);

    // Single line with exact cycle timing (data-only line format)
    line1 = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    model_word(32'h0123ABCD, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h0123ABCD;
    step();
    in_valid = 1'b0;
    check("t1_busy", busy, 1'b1);
    check("t1_in_ready_low", in_ready, 1'b0);
`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
    check("t1_first_valid", out_valid, 1'b1);
    check("t1_first_char", out_char, 8'h30);
    wait_and_compare("t1");
`else
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      check($sformatf("t1_valid[%0d]", k), out_valid, 1'b1);
      check($sformatf("t1_char[%0d]", k), out_char, line1[k]);
    end
    check("t1_in_ready_n10", in_ready, 1'b0);
    step();
    check("t1_in_ready_n11", in_ready, 1'b1);
    check("t1_out_valid_n11", out_valid, 1'b0);
    wait_and_compare("t1");
`endif

    // Back-to-back words with out_ready toggling
    rdy_mode = 1;
    model_word(32'hDEADBEEF, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    model_word(32'h00000000, 1'b0);
    send_word(32'h00000000, 1'b0);
    wait_and_compare("t2");
    check("t2_stall_stable", 64'(stall_viol), 64'd0);

    // Standalone restart, then three words with restart on the third
    rdy_mode = 0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    m_addr = 32'd0;
    model_word(32'h11112222, 1'b0);
    send_word(32'h11112222, 1'b0);
    model_word(32'h33334444, 1'b0);
    send_word(32'h33334444, 1'b0);
    model_word(32'h55556666, 1'b1);
    send_word(32'h55556666, 1'b1);
    wait_and_compare("t3");

`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
    // Address counter wrap
    force dut.r_addr_cnt = 32'hFFFFFFFC;
    step();
    release dut.r_addr_cnt;
    m_addr = 32'hFFFFFFFC;
    model_word(32'hCAFEF00D, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    model_word(32'h0BADC0DE, 1'b0);
    send_word(32'h0BADC0DE, 1'b0);
    wait_and_compare("t4");
`endif

    // Reset mid-line after 3 characters
    send_word(32'h89ABCDEF, 1'b0);
    sent_q.delete();
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    check("t5_valid_fall", out_valid, 1'b0);
    check("t5_busy_rst", busy, 1'b0);
    check("t5_char_rst", out_char, 8'h00);
    step();
    step();
    check("t5_busy_hold", busy, 1'b0);
    reset = 1'b0;
    step();
    check("t5_in_ready", in_ready, 1'b1);
    check("t5_busy_after", busy, 1'b0);
    g_base = got_q.size();
    exp_q.delete();
    m_addr = 32'd0;
    model_word(32'h76543210, 1'b0);
    send_word(32'h76543210, 1'b0);
    wait_and_compare("t5");

    // Random words, random back-pressure and restarts
    rdy_mode = 2;
    sent_q.delete();
    rbase = g_base;
    for (int i = 0; i < 30; i++) begin
      logic rs;
      w  = $urandom;
      rs = ($urandom_range(0, 7) == 0);
      model_word(w, rs);
      send_word(w, rs);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_and_compare("t6");
    check("t6_stall_stable", 64'(stall_viol), 64'd0);

    // Loopback: parse the received text back into words
    lines = 0;
    perr  = 0;
    val   = 32'd0;
    for (int i = rbase; i < got_q.size(); i++) begin
      c = got_q[i];
      if (c >= 8'h30 && c <= 8'h39)      val = {val[27:0], 4'(c - 8'h30)};
      else if (c >= 8'h41 && c <= 8'h46) val = {val[27:0], 4'(c - 8'h37)};
      else if (c == 8'h3A || c == 8'h20) val = 32'd0;
      else if (c == 8'h0D) begin
        if (lines < sent_q.size())
          check($sformatf("loop[%0d]", lines), val, sent_q[lines]);
        lines++;
        val = 32'd0;
      end else if (c != 8'h0A) perr++;
    end
    check("loop_lines", 64'(lines), 64'(sent_q.size()));
    check("loop_parse_err", 64'(perr), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
